// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage with a prefetch queue between PC generation and IF/ID.
// Fetch keeps running while decode stalls; a branch flushes the queue and cancels any in-flight read.
module instruction_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    PC_STEP     = 4,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               pcWrite,
  input  logic                               ifIdWrite,
  input  logic                               branch,
  input  logic [ADDR_WIDTH-1:0]              branchProgramCounter,
  output logic                               imemReq,
  output logic [ADDR_WIDTH-1:0]              imemAddr,
  input  logic [DATA_WIDTH-1:0]              imemData,
  output logic [ADDR_WIDTH-1:0]              programCounterOut,
  output logic [DATA_WIDTH-1:0]              instruction,
  output logic                               instrValid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queueCount
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  logic [ADDR_WIDTH-1:0] q_pc_mem   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_data_mem [QUEUE_DEPTH];

  logic room, issue, ret_valid, q_empty, pop, bypass, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The outstanding request already owns a slot, so it counts against room.
  assign room      = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(QUEUE_DEPTH);
  assign issue     = resetN & pcWrite & (branch | room);
  assign ret_valid = inflight_q & ~branch;
  assign q_empty   = (count_q == '0);
  assign pop       = ifIdWrite & ~branch & ~q_empty;
  assign bypass    = ifIdWrite & ~branch & q_empty & ret_valid;
  assign push      = ret_valid & ~bypass;

  assign imemReq  = issue;
  assign imemAddr = branch ? branchProgramCounter : fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue)
      inflight_pc_d = imemAddr;
    if (branch)
      fetch_pc_d = pcWrite ? branchProgramCounter + STEP : branchProgramCounter;
    else if (issue)
      fetch_pc_d = fetch_pc_q + STEP;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (branch) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Bypass only when the queue is empty keeps IF/ID in program order.
  always_comb begin
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    if (branch) begin
      valid_d = 1'b0;
    end else if (ifIdWrite) begin
      if (!q_empty) begin
        pc_out_d = q_pc_mem[head_q];
        instr_d  = q_data_mem[head_q];
        valid_d  = 1'b1;
      end else if (ret_valid) begin
        pc_out_d = inflight_pc_q;
        instr_d  = imemData;
        valid_d  = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      pc_out_q      <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      pc_out_q      <= pc_out_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_mem[tail_q]   <= inflight_pc_q;
      q_data_mem[tail_q] <= imemData;
    end
  end

  assign programCounterOut = pc_out_q;
  assign instruction       = instr_q;
  assign instrValid        = valid_q;
  assign queueCount        = count_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench: per-cycle vector table for the main stream, plus hand sequences
// for async reset and 8-bit PC wrap-around.
module tb_instruction_fetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        resetN, pcWrite, ifIdWrite, branch;
  logic [31:0] branchProgramCounter;
  logic        imemReq;
  logic [31:0] imemAddr, imemData, programCounterOut, instruction;
  logic        instrValid;
  logic [2:0]  queueCount;

  logic        resetN8, pcWrite8, ifIdWrite8, branch8;
  logic [7:0]  branchPc8;
  logic        imemReq8;
  logic [7:0]  imemAddr8, pcOut8;
  logic [31:0] imemData8, instr8;
  logic        instrValid8;
  logic [2:0]  queueCount8;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch_queue u_dut (
    .clk(clk), .resetN(resetN), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .branch(branch), .branchProgramCounter(branchProgramCounter),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemData(imemData),
    .programCounterOut(programCounterOut), .instruction(instruction),
    .instrValid(instrValid), .queueCount(queueCount)
  );

  instruction_fetch_queue #(.ADDR_WIDTH(8)) u_dut8 (
    .clk(clk), .resetN(resetN8), .pcWrite(pcWrite8), .ifIdWrite(ifIdWrite8),
    .branch(branch8), .branchProgramCounter(branchPc8),
    .imemReq(imemReq8), .imemAddr(imemAddr8), .imemData(imemData8),
    .programCounterOut(pcOut8), .instruction(instr8),
    .instrValid(instrValid8), .queueCount(queueCount8)
  );

  // One-cycle synchronous memory; garbage when no request so stray captures show up.
  always_ff @(posedge clk) begin
    imemData  <= imemReq  ? (imemAddr ^ K) : 32'hDEAD_BEEF;
    imemData8 <= imemReq8 ? ({24'h0, imemAddr8} ^ K) : 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic        pw, iw, br;
    logic [31:0] bpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs [35];

  function automatic vec_t mk(bit pw, bit iw, bit br, int bpc, bit req, int addr,
                              bit valid, int pc, int instr, int cnt);
    vec_t v;
    v.pw = pw; v.iw = iw; v.br = br; v.bpc = bpc;
    v.req = req; v.addr = addr; v.valid = valid;
    v.pc = pc; v.instr = instr; v.cnt = 3'(cnt);
    return v;
  endfunction

  function automatic int kx(int pc);
    return pc ^ K;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    pcWrite = v.pw; ifIdWrite = v.iw; branch = v.br; branchProgramCounter = v.bpc;
    #2;
    $display("vec %0d: req=%0d addr=%h valid=%0d pc=%h instr=%h cnt=%0d",
             idx, imemReq, imemAddr, instrValid, programCounterOut, instruction, queueCount);
    check($sformatf("v%0d_req", idx),   {31'b0, imemReq},    {31'b0, v.req});
    check($sformatf("v%0d_addr", idx),  imemAddr,            v.addr);
    check($sformatf("v%0d_valid", idx), {31'b0, instrValid}, {31'b0, v.valid});
    check($sformatf("v%0d_pc", idx),    programCounterOut,   v.pc);
    check($sformatf("v%0d_instr", idx), instruction,         v.instr);
    check($sformatf("v%0d_cnt", idx),   {29'b0, queueCount}, {29'b0, v.cnt});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] ea, ep;

    //             pw iw br bpc   req addr  valid pc   instr     cnt
    vecs[0]  = mk(1, 1, 0, 0,    1, 0,    0, 0,   0,        0);
    vecs[1]  = mk(1, 1, 0, 0,    1, 4,    0, 0,   0,        0);
    vecs[2]  = mk(1, 1, 0, 0,    1, 8,    1, 0,   kx(0),    0);
    vecs[3]  = mk(1, 1, 0, 0,    1, 12,   1, 4,   kx(4),    0);
    vecs[4]  = mk(1, 1, 1, 48,   1, 48,   1, 8,   kx(8),    0);
    vecs[5]  = mk(1, 1, 0, 0,    1, 52,   0, 8,   kx(8),    0);
    vecs[6]  = mk(1, 1, 0, 0,    1, 56,   1, 48,  kx(48),   0);
    vecs[7]  = mk(1, 1, 0, 0,    1, 60,   1, 52,  kx(52),   0);
    vecs[8]  = mk(1, 1, 0, 0,    1, 64,   1, 56,  kx(56),   0);
    vecs[9]  = mk(1, 0, 0, 0,    1, 68,   1, 60,  kx(60),   0);
    vecs[10] = mk(1, 0, 0, 0,    1, 72,   1, 60,  kx(60),   1);
    vecs[11] = mk(1, 0, 0, 0,    1, 76,   1, 60,  kx(60),   2);
    vecs[12] = mk(1, 0, 0, 0,    0, 80,   1, 60,  kx(60),   3);
    vecs[13] = mk(1, 0, 0, 0,    0, 80,   1, 60,  kx(60),   4);
    vecs[14] = mk(1, 0, 0, 0,    0, 80,   1, 60,  kx(60),   4);
    vecs[15] = mk(1, 0, 0, 0,    0, 80,   1, 60,  kx(60),   4);
    vecs[16] = mk(1, 0, 0, 0,    0, 80,   1, 60,  kx(60),   4);
    vecs[17] = mk(1, 1, 0, 0,    0, 80,   1, 60,  kx(60),   4);
    vecs[18] = mk(1, 1, 0, 0,    1, 80,   1, 64,  kx(64),   3);
    vecs[19] = mk(1, 1, 0, 0,    1, 84,   1, 68,  kx(68),   2);
    vecs[20] = mk(1, 1, 0, 0,    1, 88,   1, 72,  kx(72),   2);
    vecs[21] = mk(1, 1, 0, 0,    1, 92,   1, 76,  kx(76),   2);
    vecs[22] = mk(1, 0, 0, 0,    1, 96,   1, 80,  kx(80),   2);
    vecs[23] = mk(1, 0, 0, 0,    0, 100,  1, 80,  kx(80),   3);
    vecs[24] = mk(1, 0, 0, 0,    0, 100,  1, 80,  kx(80),   4);
    vecs[25] = mk(1, 0, 1, 100,  1, 100,  1, 80,  kx(80),   4);
    vecs[26] = mk(1, 1, 0, 0,    1, 104,  0, 80,  kx(80),   0);
    vecs[27] = mk(0, 1, 0, 0,    0, 108,  1, 100, kx(100),  0);
    vecs[28] = mk(0, 1, 0, 0,    0, 108,  1, 104, kx(104),  0);
    vecs[29] = mk(0, 1, 0, 0,    0, 108,  0, 104, kx(104),  0);
    vecs[30] = mk(1, 1, 0, 0,    1, 108,  0, 104, kx(104),  0);
    vecs[31] = mk(1, 1, 0, 0,    1, 112,  0, 104, kx(104),  0);
    vecs[32] = mk(1, 1, 0, 0,    1, 116,  1, 108, kx(108),  0);
    vecs[33] = mk(1, 0, 0, 0,    1, 120,  1, 112, kx(112),  0);
    vecs[34] = mk(1, 0, 0, 0,    1, 124,  1, 112, kx(112),  1);

    resetN = 1'b0; pcWrite = 1'b1; ifIdWrite = 1'b1; branch = 1'b0; branchProgramCounter = '0;
    resetN8 = 1'b0; pcWrite8 = 1'b0; ifIdWrite8 = 1'b0; branch8 = 1'b0; branchPc8 = '0;
    @(posedge clk); @(posedge clk); #1;

    check("rst_req",   {31'b0, imemReq},    32'd0);
    check("rst_valid", {31'b0, instrValid}, 32'd0);
    check("rst_pc",    programCounterOut,   32'd0);
    check("rst_instr", instruction,         32'd0);
    check("rst_cnt",   {29'b0, queueCount}, 32'd0);
    $display("reset: req=%0d valid=%0d pc=%h cnt=%0d", imemReq, instrValid, programCounterOut, queueCount);

    resetN = 1'b1;
    for (int i = 0; i < 35; i++)
      run_vec(i, vecs[i]);

    // Async reset with two entries queued and a read in flight.
    pcWrite = 1'b0; ifIdWrite = 1'b0;
    #1;
    check("pre_rst_cnt", {29'b0, queueCount}, 32'd2);
    pcWrite = 1'b1; ifIdWrite = 1'b1;
    resetN = 1'b0;
    #1;
    $display("async reset: req=%0d valid=%0d pc=%h cnt=%0d", imemReq, instrValid, programCounterOut, queueCount);
    check("arst_req",   {31'b0, imemReq},    32'd0);
    check("arst_valid", {31'b0, instrValid}, 32'd0);
    check("arst_pc",    programCounterOut,   32'd0);
    check("arst_instr", instruction,         32'd0);
    check("arst_cnt",   {29'b0, queueCount}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b1;
    #1;
    check("post_rst_req",  {31'b0, imemReq}, 32'd1);
    check("post_rst_addr", imemAddr,         32'd0);
    @(posedge clk); #1;
    check("post_rst_addr1",  imemAddr,            32'd4);
    check("post_rst_valid1", {31'b0, instrValid}, 32'd0);
    @(posedge clk); #1;
    $display("after reset: addr=%h valid=%0d pc=%h instr=%h", imemAddr, instrValid, programCounterOut, instruction);
    check("post_rst_valid2", {31'b0, instrValid}, 32'd1);
    check("post_rst_pc2",    programCounterOut,   32'd0);
    check("post_rst_instr2", instruction,         K);

    // 8-bit PC: branch to F8 and run across the wrap.
    resetN8 = 1'b1; pcWrite8 = 1'b1; ifIdWrite8 = 1'b1;
    for (int d = 0; d < 6; d++) begin
      branch8   = (d == 0);
      branchPc8 = 8'hF8;
      #2;
      ea = 8'hF8 + 8'(4 * d);
      ep = 8'hF8 + 8'(4 * (d - 2));
      $display("wrap %0d: req=%0d addr=%h valid=%0d pc=%h instr=%h",
               d, imemReq8, imemAddr8, instrValid8, pcOut8, instr8);
      check($sformatf("w%0d_req", d),  {31'b0, imemReq8}, 32'd1);
      check($sformatf("w%0d_addr", d), {24'b0, imemAddr8}, {24'b0, ea});
      if (d >= 2) begin
        check($sformatf("w%0d_valid", d), {31'b0, instrValid8}, 32'd1);
        check($sformatf("w%0d_pc", d),    {24'b0, pcOut8},      {24'b0, ep});
        check($sformatf("w%0d_instr", d), instr8,               {24'b0, ep} ^ K);
      end else begin
        check($sformatf("w%0d_valid", d), {31'b0, instrValid8}, 32'd0);
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Parametrised successor to the single-register instruction fetch stage.
- Decouples PC generation from the IF/ID register with a prefetch queue, so the fetch unit keeps fetching while decode is stalled.
- Talks to an external instruction memory with 1-cycle synchronous read latency.
- Supports branch redirect with queue flush and in-flight cancel, a same-cycle empty-queue bypass, and a stall on each side.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- PC_STEP, 4, PC increment per fetch.
- QUEUE_DEPTH, 4, prefetch queue entries; must be ≥2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- pcWrite  in  1  1 = fetch side may issue a request and advance the PC.
- ifIdWrite  in  1  1 = IF/ID register may update; 0 = decode stall, hold.
- branch  in  1  redirect request, one-cycle pulse.
- branchProgramCounter  in  ADDR_WIDTH  redirect target.
- imemReq  out  1  read request this cycle (combinational).
- imemAddr  out  ADDR_WIDTH  read address (combinational).
- imemData  in  DATA_WIDTH  read data, valid in the cycle after the request.
- programCounterOut  out  ADDR_WIDTH  IF/ID PC.
- instruction  out  DATA_WIDTH  IF/ID instruction.
- instrValid  out  1  IF/ID holds a real instruction; 0 = bubble.
- queueCount  out  $clog2(QUEUE_DEPTH+1)  occupied queue entries.

Behaviour:
- Reset (resetN=0, async):
  - fetchPc=RESET_PC.
  - Queue empty, queueCount=0.
  - In-flight flag=0.
  - programCounterOut=0, instruction=0, instrValid=0.
  - imemReq=0 while reset is asserted.
  - Any in-flight return is discarded.
- Room: room = (queueCount + inflight) < QUEUE_DEPTH, where inflight counts the single outstanding request. A pop in the current cycle does not add room for this cycle's issue.
- Issue without branch:
  - imemReq = pcWrite & room; imemAddr = fetchPc.
  - On issue: fetchPc += PC_STEP, modulo 2^ADDR_WIDTH (wraps silently).
  - Set inflight, and record inflightPc = fetchPc.
- Issue with branch:
  - Queue cleared; in-flight flag cleared, so the next cycle's imemData is ignored.
  - If pcWrite=1: imemReq=1, imemAddr=branchProgramCounter, fetchPc <= branchProgramCounter+PC_STEP, new in-flight recorded.
  - If pcWrite=0: no request, fetchPc <= branchProgramCounter.
  - Room is ignored on branch, since the queue is being cleared.
  - Target low bits are used unmodified.
- Return: in the cycle after a non-cancelled issue, the pair {inflightPc, imemData} is the return. It goes to IF/ID via bypass or is pushed to the queue tail.
- IF/ID update, when ifIdWrite=1 and branch=0:
  - Queue non-empty: pop head into programCounterOut/instruction, instrValid<=1. A same-cycle return is pushed.
  - Queue empty with a return: bypass the return directly into IF/ID, instrValid<=1, no push.
  - Queue empty, no return: instrValid<=0; PC and instruction hold their old values.
- IF/ID when ifIdWrite=0: IF/ID holds; a return is pushed. A push can never overflow because of the room rule.
- IF/ID when branch=1: instrValid<=0 regardless of ifIdWrite; PC and instruction hold.
- Order: queue is FIFO; bypass is only allowed when the queue is empty, so program order is preserved.
- Latency: request issued in cycle n reaches IF/ID outputs in cycle n+2 via bypass, or later if queued.
- Steady state: with pcWrite=ifIdWrite=1 and no branch, instrValid=1 every cycle; PC advances by PC_STEP per cycle.
- Simultaneous push and pop on a full queue: legal; count unchanged.
- Async reset mid-operation clears everything immediately. The first request after reset release is to RESET_PC.

Test Plan:
- Bench memory returns imemData = imemAddr ^ 32'hA5A5_0000, one cycle after the request.
- Reset release, pcWrite=ifIdWrite=1 → imemAddr = 0,4,8,…; instrValid rises 2 cycles after the first request; programCounterOut = 0,4,8… with matching data; queueCount stays 0.
- Branch pulse to 48 after 3 fetches → cycle after branch: instrValid=0 and in-flight return dropped; next valid PC = 48, then 52, 56; no stale PC appears.
- ifIdWrite=0 for 8 cycles → queueCount reaches 4 (QUEUE_DEPTH), imemReq=0 while full, IF/ID holds. Release → PCs continue in order with no gap, no duplicate, and instrValid=1 every cycle.
- Branch to 100 while ifIdWrite=0 and the queue is full → queueCount=0, instrValid=0. After release, first valid PC = 100.
- pcWrite=0 for 3 cycles with a drained queue → imemReq=0, instrValid=0 bubbles, fetchPc unchanged; resumes at the same PC.
- ADDR_WIDTH=8, branch to 8'hF8 → PCs F8, FC, 00, 04 (wrap-around).
- resetN pulsed low mid-stream with the queue at 2 → outputs zero asynchronously; after release, first request address = RESET_PC.
